// File: rtl/coef_load_ctrl.sv
// rtl/coef_load_ctrl.sv - coefficient RAM load/readback sequencer for left/right channel RAMs
module coef_load_ctrl #(
   parameter int AW = 14,
   parameter int DW = 36
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cmd_start,
   input  logic          cmd_chan,
   input  logic          cmd_rd,
   input  logic [AW-1:0] cmd_base,
   input  logic [AW:0]   cmd_len,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] addrLrw,
   output logic [AW-1:0] addrRrw,
   output logic [DW-1:0] datainLrw,
   output logic [DW-1:0] datainRrw,
   output logic          weL,
   output logic          weR,
   input  logic [DW-1:0] dataoutLrw,
   input  logic [DW-1:0] dataoutRrw
);

   typedef enum logic [2:0] {IDLE, LOAD, RADDR, RCAPT, ROUT, DONE} state_t;

   state_t        state;
   logic          chanReg;
   logic [AW-1:0] baseReg;
   logic [AW:0]   lenReg;
   logic [AW:0]   idx;
   logic [AW-1:0] curAddr;
   logic [AW-1:0] nextAddr;
   logic [AW:0]   idxInc;

   // Address arithmetic is AW bits wide so the wrap past the top word is free.
   assign curAddr  = baseReg + idx[AW-1:0];
   assign nextAddr = curAddr + AW'(1);
   assign idxInc   = idx + (AW+1)'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         chanReg   <= 1'b0;
         baseReg   <= '0;
         lenReg    <= '0;
         idx       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         addrLrw   <= '0;
         addrRrw   <= '0;
         datainLrw <= '0;
         datainRrw <= '0;
         weL       <= 1'b0;
         weR       <= 1'b0;
      end else begin
         done <= 1'b0;
         weL  <= 1'b0;
         weR  <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_start) begin
                  chanReg   <= cmd_chan;
                  baseReg   <= cmd_base;
                  lenReg    <= cmd_len;
                  idx       <= '0;
                  busy      <= 1'b1;
                  addrLrw   <= '0;
                  addrRrw   <= '0;
                  datainLrw <= '0;
                  datainRrw <= '0;
                  if (cmd_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (!cmd_rd) begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                  end else begin
                     state <= RADDR;
                     if (cmd_chan) addrRrw <= cmd_base;
                     else          addrLrw <= cmd_base;
                  end
               end
            end
            LOAD: begin
               // idx==len is the drain cycle carrying the final write pulse.
               if (idx == lenReg) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (in_valid && in_ready) begin
                  idx <= idxInc;
                  if (chanReg) begin
                     weR       <= 1'b1;
                     addrRrw   <= curAddr;
                     datainRrw <= in_data;
                  end else begin
                     weL       <= 1'b1;
                     addrLrw   <= curAddr;
                     datainLrw <= in_data;
                  end
                  if (idxInc == lenReg) in_ready <= 1'b0;
               end
            end
            RADDR: state <= RCAPT;
            RCAPT: begin
               out_data  <= chanReg ? dataoutRrw : dataoutLrw;
               out_valid <= 1'b1;
               state     <= ROUT;
            end
            ROUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  idx       <= idxInc;
                  if (idxInc == lenReg) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RADDR;
                     if (chanReg) addrRrw <= nextAddr;
                     else         addrLrw <= nextAddr;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
